csr_bus_arbiter: RTL and testbench
==================================

Name: csr_bus_arbiter

Overview:
- Shares the single CSR peripheral bus (ID, counter, UART, pins and timer CSR blocks) between two requesters: port 0 (CPU pipeline) and port 1 (debug/host loader).
- Follows the split bus timing used by every CSR peripheral: address in cycle T (D), read/modify/wdata in T+1 (E), and registered rdata/valid visible in T+2 (M).
- Arbitrates, drives each stage at the correct cycle, and routes every response back to the port that issued it.
- Fully pipelined: one grant per cycle.

Parameters:
- MAX_WAIT, 4: consecutive cycles port 1 may be denied while requesting before it is force-granted (fixed-priority mode only). Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req0 / req1  in  1  port request
- addr0 / addr1  in  12  CSR address
- read0 / read1  in  1  read intent
- modify0 / modify1  in  3  000 none, 001 write, 010 set, 011 clear
- wdata0 / wdata1  in  32  write data
- gnt0 / gnt1  out  1  combinational grant; the request is accepted in this cycle
- rsp_valid0 / rsp_valid1  out  1  response strobe
- rsp_rdata0 / rsp_rdata1  out  32  read data
- rsp_hit0 / rsp_hit1  out  1  a peripheral claimed the address
- bus_addr  out  12  to all CSR blocks (D stage)
- bus_read  out  1  E stage
- bus_modify  out  3  E stage
- bus_wdata  out  32  E stage
- bus_rdata  in  32  OR of peripheral rdata (M stage)
- bus_valid  in  1  OR of peripheral valid (M stage)

Behaviour:
- Grant, cycle T:
  - At most one of gnt0/gnt1 is high.
  - gnt is never high without the matching req.
  - A port's addr/read/modify/wdata are sampled only in the cycle its gnt=1.
  - The requester holds its request fields until granted; changing them while not granted is legal and simply retargets the request.
- Fixed priority (default):
  - Port 0 wins, except when the starvation counter wait1 == MAX_WAIT and req1=1; then port 1 wins.
  - wait1 is 4 bits. It increments when req1 & ~gnt1, saturates at MAX_WAIT, and clears when gnt1=1 or req1=0.
- D stage, T:
  - bus_addr = granted port's addr, combinationally.
  - With no grant, bus_addr = 12'h000.
- E stage, T+1:
  - Registers s1_valid, s1_port, s1_read, s1_modify and s1_wdata are captured at the end of T.
  - They drive bus_read, bus_modify and bus_wdata.
  - When s1_valid=0: bus_modify=000, bus_read=0, bus_wdata=0. This guarantees no spurious write.
- M stage, T+2:
  - Registers s2_valid and s2_port are shifted from stage 1.
  - rsp_validN = s2_valid & (s2_port==N).
  - rsp_rdataN = bus_rdata and rsp_hitN = bus_valid when rsp_validN=1; otherwise 0.
  - Unclaimed address: rsp_valid=1, rsp_hit=0, rdata=0.
- Latency:
  - Grant to response is exactly 2 cycles.
  - Up to 2 transactions are in flight; responses return in grant order.
- Back-to-back access to the same CSR:
  - A write granted in T updates the CSR at the end of T+1.
  - A read granted in T+1 samples in T+2 and observes the new value. The arbiter inserts no bubbles.
- Reset (rst=1, synchronous):
  - s1_valid=0, s2_valid=0, wait1=0, priority pointer=0.
  - gnt0=gnt1=0 while rst=1.
  - All rsp_* outputs are 0 and bus_addr=0, bus_modify=000, bus_read=0, bus_wdata=0.
  - Reset mid-operation discards in-flight transactions: no rsp_valid for them, and no bus_modify≠000 in the following cycle.
  - A write whose E stage coincides with the reset cycle is suppressed.
- Simultaneous events: when both ports request every cycle with MAX_WAIT=4, the pattern is 0,0,0,0,1,0,0,0,0,1…

Optional Feature:
- Macro: CSR_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port. Reset value 0.
  - On any grant, the pointer moves to the other port.
  - A lone requester is always granted.
  - MAX_WAIT and wait1 are removed.
  - Both ports requesting every cycle yields 0,1,0,1…
- Undefined: fixed priority with starvation counter as above.

Test Plan:
- Port 0 only: write 001 of 0x5 to 12'hBC1, then read 12'hBC1 the next cycle.
  - bus_modify=001 and bus_wdata=5 one cycle after the grant.
  - The read's rsp_valid0 arrives 2 cycles after its grant with rsp_rdata0=0x5, rsp_hit0=1.
- Port 1 reads 12'hF11, then 12'h123.
  - First read: rsp_valid1=1, rsp_hit1=1, rdata=VENDORID.
  - Second read: rsp_valid1=1, rsp_hit1=0, rdata=0.
  - rsp_valid0 stays 0 throughout.
- Both ports request continuously for 15 cycles, MAX_WAIT=4.
  - Grant order: 0,0,0,0,1,0,0,0,0,1,…
  - No cycle has both grants; responses are tagged to the correct port.
  - With CSR_ARB_RR_EN: 0,1,0,1….
- Port 0 read of 12'hC00 and port 1 read of 12'hC02 interleaved every cycle.
  - Each rsp_rdata matches the peripheral model for its own address.
  - Responses stay in grant order.
- Port 0 write 12'hBC1 := 0xA granted, rst=1 in the next cycle.
  - bus_modify=000 during reset; the pins keep their reset value; no rsp_valid.
  - After reset release, a read of 12'hBC1 returns the reset value.
- Idle, no requests: bus_modify=000, bus_read=0, bus_addr=0, and all rsp_valid=0 every cycle.

Source files
------------

// File: rtl/csr_bus_arbiter.sv
// csr_bus_arbiter: shares the split-timing CSR bus (D addr / E read-modify-wdata / M rdata-valid) between two ports.
// Optional macro CSR_ARB_RR_EN selects round-robin arbitration instead of fixed priority with a starvation guard.
module csr_bus_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [11:0] addr0,
  input  logic        read0,
  input  logic [2:0]  modify0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic [11:0] addr1,
  input  logic        read1,
  input  logic [2:0]  modify1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid0,
  output logic [31:0] rsp_rdata0,
  output logic        rsp_hit0,
  output logic        rsp_valid1,
  output logic [31:0] rsp_rdata1,
  output logic        rsp_hit1,
  output logic [11:0] bus_addr,
  output logic        bus_read,
  output logic [2:0]  bus_modify,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_valid
);

`ifdef CSR_ARB_RR_EN
  logic ptr_q, ptr_d;

  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    ptr_d = ptr_q;
    if (!rst) begin
      if (req0 && req1) begin
        gnt0 = ~ptr_q;
        gnt1 = ptr_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
    // Preference always moves to the port that did not just win.
    if (gnt0) begin
      ptr_d = 1'b1;
    end else if (gnt1) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait1_q, wait1_d;

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    wait1_d = wait1_q;
    if (!rst) begin
      if (req1 && (!req0 || (wait1_q == WAIT_LIMIT))) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = req0;
      end
    end
    if (!req1 || gnt1) begin
      wait1_d = '0;
    end else if (wait1_q < WAIT_LIMIT) begin
      wait1_d = wait1_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait1_q <= '0;
    end else begin
      wait1_q <= wait1_d;
    end
  end
`endif

  logic        s1_valid_q, s1_valid_d;
  logic        s1_port_q, s1_port_d;
  logic        s1_read_q, s1_read_d;
  logic [2:0]  s1_modify_q, s1_modify_d;
  logic [31:0] s1_wdata_q, s1_wdata_d;
  logic        s2_valid_q, s2_valid_d;
  logic        s2_port_q, s2_port_d;

  always_comb begin
    bus_addr    = '0;
    s1_valid_d  = gnt0 | gnt1;
    s1_port_d   = gnt1;
    s1_read_d   = 1'b0;
    s1_modify_d = '0;
    s1_wdata_d  = '0;
    if (gnt1) begin
      bus_addr    = addr1;
      s1_read_d   = read1;
      s1_modify_d = modify1;
      s1_wdata_d  = wdata1;
    end else if (gnt0) begin
      bus_addr    = addr0;
      s1_read_d   = read0;
      s1_modify_d = modify0;
      s1_wdata_d  = wdata0;
    end
    s2_valid_d = s1_valid_q;
    s2_port_d  = s1_port_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_port_q   <= 1'b0;
      s1_read_q   <= 1'b0;
      s1_modify_q <= '0;
      s1_wdata_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_port_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_port_q   <= s1_port_d;
      s1_read_q   <= s1_read_d;
      s1_modify_q <= s1_modify_d;
      s1_wdata_q  <= s1_wdata_d;
      s2_valid_q  <= s2_valid_d;
      s2_port_q   <= s2_port_d;
    end
  end

  // Stage outputs are also gated by rst so a write whose E stage lands in the reset cycle never reaches a CSR.
  always_comb begin
    bus_read   = 1'b0;
    bus_modify = '0;
    bus_wdata  = '0;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;
    rsp_rdata0 = '0;
    rsp_rdata1 = '0;
    rsp_hit0   = 1'b0;
    rsp_hit1   = 1'b0;
    if (!rst && s1_valid_q) begin
      bus_read   = s1_read_q;
      bus_modify = s1_modify_q;
      bus_wdata  = s1_wdata_q;
    end
    if (!rst && s2_valid_q) begin
      if (s2_port_q) begin
        rsp_valid1 = 1'b1;
        rsp_rdata1 = bus_rdata;
        rsp_hit1   = bus_valid;
      end else begin
        rsp_valid0 = 1'b1;
        rsp_rdata0 = bus_rdata;
        rsp_hit0   = bus_valid;
      end
    end
  end

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Directed bench for csr_bus_arbiter with a small split-timing CSR peripheral model on the bus side.
module tb_csr_bus_arbiter;
  localparam logic [31:0] VENDORID    = 32'h0000_0489;
  localparam logic [31:0] CYCLE_VAL   = 32'h1111_0C00;
  localparam logic [31:0] INSTRET_VAL = 32'h2222_0C02;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0, read0, req1, read1;
  logic [11:0] addr0, addr1;
  logic [2:0]  modify0, modify1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        rsp_valid0, rsp_hit0, rsp_valid1, rsp_hit1;
  logic [31:0] rsp_rdata0, rsp_rdata1;
  logic [11:0] bus_addr;
  logic        bus_read;
  logic [2:0]  bus_modify;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_valid;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  csr_bus_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .read0(read0), .modify0(modify0), .wdata0(wdata0),
    .req1(req1), .addr1(addr1), .read1(read1), .modify1(modify1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid0(rsp_valid0), .rsp_rdata0(rsp_rdata0), .rsp_hit0(rsp_hit0),
    .rsp_valid1(rsp_valid1), .rsp_rdata1(rsp_rdata1), .rsp_hit1(rsp_hit1),
    .bus_addr(bus_addr), .bus_read(bus_read), .bus_modify(bus_modify),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_valid(bus_valid)
  );

  // Peripheral model: address latched at end of D, read/modify in E, registered rdata/valid in M.
  logic [11:0] p_addr_q;
  logic [31:0] p_rdata_q, pins_q, p_val;
  logic        p_valid_q, p_hit;

  always_comb begin
    p_hit = 1'b1;
    p_val = '0;
    case (p_addr_q)
      12'hF11: p_val = VENDORID;
      12'hBC1: p_val = pins_q;
      12'hC00: p_val = CYCLE_VAL;
      12'hC02: p_val = INSTRET_VAL;
      default: p_hit = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    p_addr_q  <= bus_addr;
    p_valid_q <= !rst && (bus_read || (bus_modify != 3'b000)) && p_hit;
    p_rdata_q <= (!rst && bus_read && p_hit) ? p_val : '0;
    if (rst) pins_q <= '0;
    // A write leaking into the reset cycle overrides the reset, so it stays visible afterwards.
    if (p_addr_q == 12'hBC1) begin
      case (bus_modify)
        3'b001:  pins_q <= bus_wdata;
        3'b010:  pins_q <= pins_q | bus_wdata;
        3'b011:  pins_q <= pins_q & ~bus_wdata;
        default: ;
      endcase
    end
  end

  assign bus_rdata = p_rdata_q;
  assign bus_valid = p_valid_q;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; addr0 = '0; read0 = 1'b0; modify0 = '0; wdata0 = '0;
    req1 = 1'b0; addr1 = '0; read1 = 1'b0; modify1 = '0; wdata1 = '0;
  endtask

  task automatic set_p0(input logic [11:0] a, input logic rd, input logic [2:0] m, input logic [31:0] w);
    req0 = 1'b1; addr0 = a; read0 = rd; modify0 = m; wdata0 = w;
  endtask

  task automatic set_p1(input logic [11:0] a, input logic rd, input logic [2:0] m, input logic [31:0] w);
    req1 = 1'b1; addr1 = a; read1 = rd; modify1 = m; wdata1 = w;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_bus_addr"}, 32'(bus_addr), 0);
    check_val({tag, "_bus_modify"}, 32'(bus_modify), 0);
    check_val({tag, "_bus_read"}, 32'(bus_read), 0);
    check_val({tag, "_bus_wdata"}, bus_wdata, 0);
    check_val({tag, "_rsp_valid0"}, 32'(rsp_valid0), 0);
    check_val({tag, "_rsp_valid1"}, 32'(rsp_valid1), 0);
  endtask

  logic exp_p1 [15];

  initial begin
    idle_inputs();
    for (int i = 0; i < 15; i++) begin
`ifdef CSR_ARB_RR_EN
      exp_p1[i] = (i % 2) == 1;
`else
      exp_p1[i] = (i % 5) == 4;
`endif
    end

    // Reset: grants suppressed even with both ports requesting.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_p0(12'h111, 1'b1, 3'b001, 32'hDEAD);
      set_p1(12'h222, 1'b1, 3'b001, 32'hBEEF);
      #1;
      check_val("rst_gnt0", 32'(gnt0), 0);
      check_val("rst_gnt1", 32'(gnt1), 0);
      check_quiet("rst");
    end
    @(negedge clk); rst = 1'b0; idle_inputs(); #1;
    check_quiet("post_rst");

    // Port 0: write 5 to BC1, then read it back next cycle.
    @(negedge clk); set_p0(12'hBC1, 1'b0, 3'b001, 32'h5); #1;
    check_val("t1_gnt0_w", 32'(gnt0), 1);
    check_val("t1_gnt1_w", 32'(gnt1), 0);
    check_val("t1_addr_w", 32'(bus_addr), 32'hBC1);
    @(negedge clk); set_p0(12'hBC1, 1'b1, 3'b000, 32'h0); #1;
    check_val("t1_gnt0_r", 32'(gnt0), 1);
    check_val("t1_modify", 32'(bus_modify), 1);
    check_val("t1_wdata", bus_wdata, 32'h5);
    check_val("t1_read_e_w", 32'(bus_read), 0);
    check_val("t1_rv0_early", 32'(rsp_valid0), 0);
    @(negedge clk); idle_inputs(); #1;
    check_val("t1_read_e", 32'(bus_read), 1);
    check_val("t1_modify_e_r", 32'(bus_modify), 0);
    check_val("t1_wrsp_valid0", 32'(rsp_valid0), 1);
    check_val("t1_wrsp_hit0", 32'(rsp_hit0), 1);
    @(negedge clk); #1;
    check_val("t1_rrsp_valid0", 32'(rsp_valid0), 1);
    check_val("t1_rrsp_rdata0", rsp_rdata0, 32'h5);
    check_val("t1_rrsp_hit0", 32'(rsp_hit0), 1);
    check_val("t1_rsp_valid1", 32'(rsp_valid1), 0);
    @(negedge clk); #1;
    check_val("t1_rsp_done", 32'(rsp_valid0), 0);

    // Port 1: claimed then unclaimed read.
    @(negedge clk); set_p1(12'hF11, 1'b1, 3'b000, 32'h0); #1;
    check_val("t2_gnt1_a", 32'(gnt1), 1);
    check_val("t2_addr_a", 32'(bus_addr), 32'hF11);
    @(negedge clk); set_p1(12'h123, 1'b1, 3'b000, 32'h0); #1;
    check_val("t2_gnt1_b", 32'(gnt1), 1);
    check_val("t2_rv0_b", 32'(rsp_valid0), 0);
    @(negedge clk); idle_inputs(); #1;
    check_val("t2_rv1_a", 32'(rsp_valid1), 1);
    check_val("t2_hit1_a", 32'(rsp_hit1), 1);
    check_val("t2_rdata1_a", rsp_rdata1, VENDORID);
    check_val("t2_rv0_c", 32'(rsp_valid0), 0);
    @(negedge clk); #1;
    check_val("t2_rv1_b", 32'(rsp_valid1), 1);
    check_val("t2_hit1_b", 32'(rsp_hit1), 0);
    check_val("t2_rdata1_b", rsp_rdata1, 0);
    check_val("t2_rv0_d", 32'(rsp_valid0), 0);

    // Fresh reset so the starvation counter / pointer start from zero.
    @(negedge clk); rst = 1'b1; idle_inputs();
    @(negedge clk); rst = 1'b0;

    // Both ports request continuously for 15 cycles.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i < 15) begin
        set_p0(12'hC00, 1'b1, 3'b000, 32'h0);
        set_p1(12'hC02, 1'b1, 3'b000, 32'h0);
      end else begin
        idle_inputs();
      end
      #1;
      if (i < 15) begin
        check_val($sformatf("t3_gnt0[%0d]", i), 32'(gnt0), exp_p1[i] ? 0 : 1);
        check_val($sformatf("t3_gnt1[%0d]", i), 32'(gnt1), exp_p1[i] ? 1 : 0);
      end
      if (i >= 2) begin
        check_val($sformatf("t3_rv0[%0d]", i), 32'(rsp_valid0), exp_p1[i-2] ? 0 : 1);
        check_val($sformatf("t3_rv1[%0d]", i), 32'(rsp_valid1), exp_p1[i-2] ? 1 : 0);
        check_val($sformatf("t3_rd0[%0d]", i), rsp_rdata0, exp_p1[i-2] ? 32'h0 : CYCLE_VAL);
        check_val($sformatf("t3_rd1[%0d]", i), rsp_rdata1, exp_p1[i-2] ? INSTRET_VAL : 32'h0);
      end
    end

    // Alternating lone requesters: port 0 on even cycles, port 1 on odd.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle_inputs();
      if (i < 8) begin
        if ((i % 2) == 0) set_p0(12'hC00, 1'b1, 3'b000, 32'h0);
        else              set_p1(12'hC02, 1'b1, 3'b000, 32'h0);
      end
      #1;
      if (i < 8) begin
        check_val($sformatf("t4_gnt0[%0d]", i), 32'(gnt0), ((i % 2) == 0) ? 1 : 0);
        check_val($sformatf("t4_gnt1[%0d]", i), 32'(gnt1), ((i % 2) == 1) ? 1 : 0);
      end
      if (i >= 2) begin
        check_val($sformatf("t4_rv0[%0d]", i), 32'(rsp_valid0), ((i % 2) == 0) ? 1 : 0);
        check_val($sformatf("t4_rv1[%0d]", i), 32'(rsp_valid1), ((i % 2) == 1) ? 1 : 0);
        check_val($sformatf("t4_rd0[%0d]", i), rsp_rdata0, ((i % 2) == 0) ? CYCLE_VAL : 32'h0);
        check_val($sformatf("t4_rd1[%0d]", i), rsp_rdata1, ((i % 2) == 1) ? INSTRET_VAL : 32'h0);
      end
    end

    // Reset mid-operation: read then write 0xA in flight when rst rises.
    @(negedge clk); idle_inputs(); set_p0(12'hBC1, 1'b1, 3'b000, 32'h0); #1;
    check_val("t5_gnt0_r", 32'(gnt0), 1);
    @(negedge clk); set_p0(12'hBC1, 1'b0, 3'b001, 32'hA); #1;
    check_val("t5_gnt0_w", 32'(gnt0), 1);
    @(negedge clk); rst = 1'b1; idle_inputs(); #1;
    check_quiet("t5_in_rst");
    check_val("t5_gnt0_rst", 32'(gnt0), 0);
    @(negedge clk); rst = 1'b0; #1;
    check_quiet("t5_after_rst");
    @(negedge clk); set_p0(12'hBC1, 1'b1, 3'b000, 32'h0); #1;
    check_val("t5_gnt0_rb", 32'(gnt0), 1);
    @(negedge clk); idle_inputs(); #1;
    check_val("t5_rv0_early", 32'(rsp_valid0), 0);
    @(negedge clk); #1;
    check_val("t5_rv0", 32'(rsp_valid0), 1);
    check_val("t5_hit0", 32'(rsp_hit0), 1);
    check_val("t5_rdata0", rsp_rdata0, 32'h0);

    // Idle bus stays quiet.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle_inputs(); #1;
      check_quiet($sformatf("t6_idle%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
